// File: rtl/muldiv_unit_pkg.sv
// Shared defines for the execute stage: ALU opcodes, HI/LO unit opcodes
// and the HI/LO unit FSM state encoding.
package muldiv_unit_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_NOR  = 4'd5,
        ALU_SLT  = 4'd6,
        ALU_SLTU = 4'd7
    } alu_op_e;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } md_op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MUL   = 2'd1,
        S_DIV   = 2'd2,
        S_FIXUP = 2'd3
    } md_state_e;

endpackage

// File: rtl/muldiv_unit_divider.sv
// Unsigned restoring divider: one quotient bit per i_step, 32 steps per divide.
module muldiv_divider (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_load,
    input  logic        i_step,
    input  logic        i_clear,
    input  logic [31:0] i_dividend,
    input  logic [31:0] i_divisor,
    output logic [31:0] o_quot,
    output logic [31:0] o_rem,
    output logic        o_last
);
    logic [31:0] r_quot;
    logic [31:0] r_rem;
    logic [31:0] r_divisor;
    logic [5:0]  r_cnt;
    logic [32:0] w_shift;
    logic [32:0] w_diff;

    // Shifted partial remainder needs 33 bits; bit 32 of the trial difference is the borrow.
    assign w_shift = {r_rem, r_quot[31]};
    assign w_diff  = w_shift - {1'b0, r_divisor};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_quot    <= '0;
            r_rem     <= '0;
            r_divisor <= '0;
            r_cnt     <= '0;
        end else if (i_clear) begin
            r_quot    <= '0;
            r_rem     <= '0;
            r_divisor <= '0;
            r_cnt     <= '0;
        end else if (i_load) begin
            r_quot    <= i_dividend;
            r_rem     <= '0;
            r_divisor <= i_divisor;
            r_cnt     <= '0;
        end else if (i_step) begin
            r_rem  <= w_diff[32] ? w_shift[31:0] : w_diff[31:0];
            r_quot <= {r_quot[30:0], ~w_diff[32]};
            r_cnt  <= r_cnt + 6'd1;
        end
    end

    assign o_quot = r_quot;
    assign o_rem  = r_rem;
    assign o_last = (r_cnt == 6'd31);

endmodule

// File: rtl/muldiv_unit.sv
// HI/LO multiply/divide unit: control FSM, sign handling, single-cycle
// multiplier and the architectural HI/LO registers.
module muldiv_unit
    import muldiv_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid,
    input  logic [2:0]  op_code,
    input  logic [31:0] op_x,
    input  logic [31:0] op_y,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic        div_by_zero,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    md_state_e   r_state;
    logic [31:0] r_x;
    logic [31:0] r_y;
    logic        r_signed;
    logic        r_neg_q;
    logic        r_neg_r;
    logic        r_dbz;
    logic        r_done;
    logic        r_dbz_out;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic        w_sdiv;
    logic        w_div_load;
    logic [31:0] w_mag_x;
    logic [31:0] w_mag_y;
    logic [31:0] w_quot;
    logic [31:0] w_rem;
    logic        w_div_last;
    logic signed [63:0] w_prod_s;
    logic [63:0] w_prod_u;

    assign w_sdiv     = (op_code == MD_DIV);
    assign w_mag_x    = (w_sdiv && op_x[31]) ? -op_x : op_x;
    assign w_mag_y    = (w_sdiv && op_y[31]) ? -op_y : op_y;
    assign w_div_load = (r_state == S_IDLE) && op_valid && !flush &&
                        ((op_code == MD_DIV) || (op_code == MD_DIVU));

    // Kept as separate nets so the signed product is not turned unsigned by a shared mux.
    assign w_prod_s = $signed(r_x) * $signed(r_y);
    assign w_prod_u = {32'b0, r_x} * {32'b0, r_y};

    muldiv_divider u_div (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_div_load),
        .i_step     (r_state == S_DIV),
        .i_clear    (flush),
        .i_dividend (w_mag_x),
        .i_divisor  (w_mag_y),
        .o_quot     (w_quot),
        .o_rem      (w_rem),
        .o_last     (w_div_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_x       <= '0;
            r_y       <= '0;
            r_signed  <= 1'b0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_dbz     <= 1'b0;
            r_done    <= 1'b0;
            r_dbz_out <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
        end else begin
            r_done    <= 1'b0;
            r_dbz_out <= 1'b0;
            if (flush) begin
                r_state <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (op_valid) begin
                            case (op_code)
                                MD_MULT, MD_MULTU: begin
                                    r_x      <= op_x;
                                    r_y      <= op_y;
                                    r_signed <= (op_code == MD_MULT);
                                    r_state  <= S_MUL;
                                end
                                MD_DIV, MD_DIVU: begin
                                    r_x     <= op_x;
                                    r_neg_q <= w_sdiv && (op_x[31] ^ op_y[31]);
                                    r_neg_r <= w_sdiv && op_x[31];
                                    r_dbz   <= (op_y == '0);
                                    r_state <= (op_y == '0) ? S_FIXUP : S_DIV;
                                end
                                MD_MTHI: r_hi <= op_x;
                                MD_MTLO: r_lo <= op_x;
                                default: ;
                            endcase
                        end
                    end
                    S_MUL: begin
                        {r_hi, r_lo} <= r_signed ? w_prod_s : w_prod_u;
                        r_done       <= 1'b1;
                        r_state      <= S_IDLE;
                    end
                    S_DIV: begin
                        if (w_div_last)
                            r_state <= S_FIXUP;
                    end
                    S_FIXUP: begin
                        if (r_dbz) begin
                            r_hi <= r_x;
                            r_lo <= '1;
                        end else begin
                            r_lo <= r_neg_q ? -w_quot : w_quot;
                            r_hi <= r_neg_r ? -w_rem : w_rem;
                        end
                        r_done    <= 1'b1;
                        r_dbz_out <= r_dbz;
                        r_state   <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign busy        = (r_state != S_IDLE);
    assign done        = r_done;
    assign div_by_zero = r_dbz_out;
    assign hi          = r_hi;
    assign lo          = r_lo;

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port op_valid, input, 1, request to start op_code this cycle.
REQ-004 SHALL have port op_code, input, 3, MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI or MD_MTLO.
REQ-005 SHALL have ports op_x and op_y, input, 32 each, rs (dividend/multiplicand) and rt (divisor/multiplier).
REQ-006 SHALL have port flush, input, 1, cancels any in-flight op.
REQ-007 SHALL have port busy, output, 1, op in flight; hazard unit stalls MFHI/MFLO/new ops while high.
REQ-008 SHALL have port done, output, 1, one-cycle pulse when HI/LO take a MULT/DIV result.
REQ-009 SHALL have port div_by_zero, output, 1, qualifies done for a divide with op_y==0.
REQ-010 SHALL have ports hi and lo, output, 32 each, architectural HI/LO registers.

Function
REQ-011 SHALL accept an op at edge k only when op_valid=1 and busy=0; op_valid while busy is ignored.
REQ-012 SHALL use FSM states IDLE, MUL, DIV, FIXUP; unknown op_code leaves FSM in IDLE and HI/LO unchanged.
REQ-013 MTHI/MTLO SHALL write op_x to hi/lo at edge k, no busy, no done.
REQ-014 MULT/MULTU SHALL register operands at edge k (IDLE->MUL), write the 64-bit product {hi,lo} at edge k+1 (MUL->IDLE); MULT signed, MULTU unsigned.
REQ-015 DIV/DIVU SHALL register magnitudes and result signs at edge k (IDLE->DIV), run a restoring divider one quotient bit per cycle for edges k+1..k+32, then FIXUP applies signs and writes lo=quotient, hi=remainder at edge k+33 (FIXUP->IDLE).
REQ-016 Signed divide SHALL truncate quotient toward zero; remainder takes the dividend sign.
REQ-017 0x80000000 / 0xFFFFFFFF (DIV) SHALL give lo=0x80000000, hi=0, no flag.
REQ-018 Divide with op_y==0 SHALL skip iteration (IDLE->FIXUP), write hi=op_x, lo=0xFFFFFFFF at edge k+1, and assert div_by_zero with done.
REQ-019 busy SHALL be high in every cycle where state != IDLE (MUL: 1 cycle; DIV: 33 cycles; divide-by-zero: 1 cycle).
REQ-020 done SHALL be high for exactly the one cycle after the HI/LO result write; div_by_zero low whenever done is low.
REQ-021 flush SHALL force IDLE at the next edge, discard the in-flight result, leave hi/lo unchanged, and suppress done; flush with op_valid in IDLE SHALL drop the op.
REQ-022 A new op accepted in the same cycle done is high SHALL start normally (back-to-back allowed).

Reset
REQ-023 rst SHALL immediately force state=IDLE, hi=0, lo=0, busy=0, done=0, div_by_zero=0, divider registers to 0.
REQ-024 rst asserted mid-divide SHALL abandon the op with no done pulse after release.

Structure
REQ-025 MD_* op_code encodings and FSM state encodings SHALL live in the shared defines file beside the ALU opcodes.
REQ-026 The restoring-divide iteration (partial remainder, quotient shift, 6-bit counter) SHALL be sub-module muldiv_divider; muldiv_unit holds FSM, sign handling, multiplier and HI/LO.

Verification
REQ-027 MULT op_x=0xFFFFFFFE, op_y=3 -> edge k+1 hi=0xFFFFFFFF, lo=0xFFFFFFFA, done one cycle, busy one cycle.
REQ-028 DIV op_x=-7 (0xFFFFFFF9), op_y=2 -> after 33 busy cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU same operands -> lo=0x7FFFFFFC, hi=1.
REQ-029 DIVU op_x=0x1234, op_y=0 -> edge k+1 hi=0x1234, lo=0xFFFFFFFF, done and div_by_zero high together.
REQ-030 Start DIV, assert flush at cycle k+10 -> busy low next cycle, hi/lo retain prior values, no done.
REQ-031 Start DIV, pulse rst at k+5 asynchronously -> busy, hi, lo go 0 before the next edge; MTLO 0x55 afterwards -> lo=0x55.
REQ-032 DIV 0x80000000 / -1 then MULTU accepted in the done cycle -> lo=0x80000000, hi=0, then correct product next edge.
